// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
// Holds the fetch PC, latches the fetched instruction into Decode, honours
// the hazard unit's stall/flush/redirect controls, and counts stall and
// flush cycles with saturating counters for performance debug.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != CNT_MAX)) return v + CNT_ONE;
    return v;
  endfunction

  logic [31:0]      pcf_q, pcf_d;
  logic [31:0]      instr_d_q, instr_d_d;
  logic [31:0]      pc_d_q, pc_d_d;
  logic [31:0]      pcplus4_d_q, pcplus4_d_d;
  logic             valid_d_q, valid_d_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pcplus4_f;

  // Next-state logic for the fetch PC, the IF/ID register and the counters.
  always_comb begin
    pcplus4_f   = pcf_q + 32'd4;   // wraps silently at 2^32

    // ---- Fetch: redirect beats stall, otherwise sequential ----
    pcf_d       = pcf_q;
    misalign_d  = misalign_q;
    if (PCSrcE) begin
      pcf_d      = {PCTargetE[31:2], 2'b00};
      misalign_d = misalign_q | (PCTargetE[1:0] != 2'b00);
    end else if (!StallF) begin
      pcf_d      = pcplus4_f;
    end

    // ---- IF/ID boundary: flush beats stall, otherwise capture ----
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (FlushD) begin
      instr_d_d   = NOP_INSTR;
      pc_d_d      = 32'd0;
      pcplus4_d_d = 32'd0;
      valid_d_d   = 1'b0;
    end else if (!StallD) begin
      instr_d_d   = InstrF;
      pc_d_d      = pcf_q;
      pcplus4_d_d = pcplus4_f;
      valid_d_d   = 1'b1;
    end

    // Event counters see only their own qualifier.
    stall_cnt_d = sat_inc(stall_cnt_q, StallF);
    flush_cnt_d = sat_inc(flush_cnt_q, FlushD);
  end

  // State registers; reset overrides every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= 32'd0;
      pcplus4_d_q <= 32'd0;
      valid_d_q   <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF         = pcf_q;
  assign InstrD      = instr_d_q;
  assign PCD         = pc_d_q;
  assign PCPlus4D    = pcplus4_d_q;
  assign ValidD      = valid_d_q;
  assign MisalignErr = misalign_q;
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;

endmodule
